// File: rtl/frag_issue_ctrl.sv
// ---------------------------------------------------------------------------
// frag_issue_ctrl
//
// Front-end sequencer between the instruction word stream and the CGRA
// decode/issue path. It tracks fragment start/end markers and the
// per-fragment allocation count. It attaches any pending T and I prefixes to
// the next D or W word, and presents one assembled instruction per output
// transfer. Illegal sequences park the block in ERR until err_clr.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input word handshake
//   in_word[31:0]       instruction word, op = [31:29]
//   out_valid/out_ready assembled instruction handshake
//   out_word[31:0]      base D/W word
//   out_has_t/out_tpay  T prefix present / its payload bits [15:0]
//   out_has_i/out_immhi I prefix present / its payload bits [25:0]
//   out_slot[6:0]       position of the instruction inside its fragment
//   frag_active         fragment open (ACTIVE state)
//   frag_done           one-cycle pulse after an accepted end marker
//   frag_count[6:0]     instructions issued in the fragment just closed
//   err/err_code[2:0]   ERR state flag and cause of the last error
//   err_clr             leave ERR
// ---------------------------------------------------------------------------
module frag_issue_ctrl #(
    parameter int NALLOC_MAX = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_has_t,
    output logic [15:0] out_tpay,
    output logic        out_has_i,
    output logic [25:0] out_immhi,
    output logic [6:0]  out_slot,
    output logic        frag_active,
    output logic        frag_done,
    output logic [6:0]  frag_count,
    output logic        err,
    output logic [2:0]  err_code,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERR    = 2'd2
    } state_t;

    localparam logic [7:0] NALLOC_LIM = 8'(NALLOC_MAX);

    state_t      state;
    state_t      state_nxt;

    logic [6:0]  nalloc;
    logic [6:0]  slot;
    logic        t_held;
    logic [15:0] tpay;
    logic        i_held;
    logic [25:0] immhi;

    logic [2:0]  op;
    logic        accept;
    logic        nalloc_ok;

    logic        do_start;
    logic        do_issue;
    logic        do_set_t;
    logic        do_set_i;
    logic        do_end;
    logic        do_err;
    logic [2:0]  err_cause;
    logic        do_clr;

    assign op        = in_word[31:29];
    // Every word class shares one ready rule, so a prefix or marker stalls
    // behind a blocked output just like a D/W word does.
    assign in_ready  = (state != ERR) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign nalloc_ok = (in_word[6:0] != 7'd0) &&
                       ({1'b0, in_word[6:0]} <= NALLOC_LIM);

    assign frag_active = (state == ACTIVE);
    assign err         = (state == ERR);

    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        do_issue  = 1'b0;
        do_set_t  = 1'b0;
        do_set_i  = 1'b0;
        do_end    = 1'b0;
        do_err    = 1'b0;
        err_cause = 3'd0;
        do_clr    = 1'b0;

        case (state)
            ERR: begin
                if (err_clr) begin
                    state_nxt = IDLE;
                    do_clr    = 1'b1;
                end
            end

            IDLE: begin
                if (accept) begin
                    // Illegal opcodes win over every other check.
                    if (op[2:1] == 2'b11) begin
                        do_err    = 1'b1;
                        err_cause = 3'd1;
                    end else if (op == 3'b101 && !in_word[28]) begin
                        if (nalloc_ok) begin
                            do_start  = 1'b1;
                            state_nxt = ACTIVE;
                        end else begin
                            do_err    = 1'b1;
                            err_cause = 3'd7;
                        end
                    end else begin
                        do_err    = 1'b1;
                        err_cause = 3'd5;
                    end
                end
            end

            ACTIVE: begin
                if (accept) begin
                    case (op)
                        3'b000, 3'b001, 3'b010: begin
                            if (slot >= nalloc) begin
                                do_err    = 1'b1;
                                err_cause = 3'd4;
                            end else begin
                                do_issue = 1'b1;
                            end
                        end
                        3'b011: begin
                            if (t_held) begin
                                do_err    = 1'b1;
                                err_cause = 3'd2;
                            end else begin
                                do_set_t = 1'b1;
                            end
                        end
                        3'b100: begin
                            if (i_held) begin
                                do_err    = 1'b1;
                                err_cause = 3'd2;
                            end else begin
                                do_set_i = 1'b1;
                            end
                        end
                        3'b101: begin
                            if (!in_word[28]) begin
                                do_err    = 1'b1;
                                err_cause = 3'd6;
                            end else if (t_held || i_held) begin
                                // A dangling prefix would otherwise be lost.
                                do_err    = 1'b1;
                                err_cause = 3'd3;
                            end else begin
                                do_end    = 1'b1;
                                state_nxt = IDLE;
                            end
                        end
                        default: begin
                            do_err    = 1'b1;
                            err_cause = 3'd1;
                        end
                    endcase
                end
            end

            default: state_nxt = IDLE;
        endcase

        if (do_err) begin
            state_nxt = ERR;
        end
    end

    // Sequencing state: fragment bookkeeping, prefix holds, error status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            nalloc     <= 7'd0;
            slot       <= 7'd0;
            t_held     <= 1'b0;
            tpay       <= 16'd0;
            i_held     <= 1'b0;
            immhi      <= 26'd0;
            frag_done  <= 1'b0;
            frag_count <= 7'd0;
            err_code   <= 3'd0;
        end else begin
            state     <= state_nxt;
            frag_done <= do_end;

            if (do_start) begin
                nalloc <= in_word[6:0];
                slot   <= 7'd0;
                t_held <= 1'b0;
                i_held <= 1'b0;
            end

            if (do_set_t) begin
                t_held <= 1'b1;
                tpay   <= in_word[15:0];
            end

            if (do_set_i) begin
                i_held <= 1'b1;
                immhi  <= in_word[25:0];
            end

            if (do_issue) begin
                slot   <= slot + 7'd1;
                t_held <= 1'b0;
                i_held <= 1'b0;
            end

            if (do_end) begin
                frag_count <= slot;
            end

            if (do_err) begin
                err_code <= err_cause;
                slot     <= 7'd0;
                t_held   <= 1'b0;
                i_held   <= 1'b0;
            end

            if (do_clr) begin
                err_code <= 3'd0;
            end
        end
    end

    // Output register: loading a new instruction on the same edge as the
    // previous one drains keeps the issue path at one instruction per cycle.
    // Payload fields of an absent prefix are forced to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_word  <= 32'd0;
            out_has_t <= 1'b0;
            out_tpay  <= 16'd0;
            out_has_i <= 1'b0;
            out_immhi <= 26'd0;
            out_slot  <= 7'd0;
        end else if (do_issue) begin
            out_valid <= 1'b1;
            out_word  <= in_word;
            out_has_t <= t_held;
            out_tpay  <= t_held ? tpay : 16'd0;
            out_has_i <= i_held;
            out_immhi <= i_held ? immhi : 26'd0;
            out_slot  <= slot;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
